// File: rtl/quadra_out_buf.sv
// quadra_out_buf: result capture FIFO behind the quadratic evaluator.
// The evaluator cannot stall. This block therefore buffers every y/y_dv
// result and presents the results as a ready/valid stream. It grants
// upstream credit (x_ready) only when every result still in flight is
// sure to find a free FIFO slot.
module quadra_out_buf #(
  parameter int Y_W   = 24,
  parameter int LAT   = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       x_dv,
  input  logic [Y_W-1:0]             y,
  input  logic                       y_dv,
  output logic                       x_ready,
  output logic [Y_W-1:0]             out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       err_unexp,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [Y_W-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  in_flight;
  logic           run;
  logic           ovf_q, err_q;

  logic           full, pop, push, ovf_evt, unexp_evt;
  logic [LW:0]    credit_sum;

  // Handshake decode. A pop frees the slot a full-FIFO push needs in the same cycle.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid & out_ready;
    push      = y_dv & (~full | pop);
    ovf_evt   = y_dv & full & ~pop;
    unexp_evt = y_dv & ~x_dv & (in_flight == '0);
  end

  // Credit counts buffered and in-flight results. This cycle's pop is not credited.
  always_comb begin
    credit_sum = {1'b0, level_q} + {1'b0, in_flight};
    x_ready    = run & (credit_sum < (LW+1)'(DEPTH));
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign err_unexp = err_q;

  // Run flop: holds credit off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) run <= 1'b0;
    else        run <= 1'b1;
  end

  // In-flight tracking. An unmatched y_dv holds the count at zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      in_flight <= '0;
    end else if (x_dv && !y_dv) begin
      if (in_flight != '1) in_flight <= in_flight + LW'(1);
    end else if (!x_dv && y_dv) begin
      if (in_flight != '0) in_flight <= in_flight - LW'(1);
    end
  end

  // FIFO storage. The contents do not need a reset because out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= y;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
    end
  end

  // Sticky error flags. A new event wins over clr_err in the same cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clr_err) | ovf_evt;
      err_q <= (err_q & ~clr_err) | unexp_evt;
    end
  end

endmodule

// File: tb/tb_quadra_out_buf.sv
// Bench for quadra_out_buf. The evaluator is modelled as a LAT-stage delay
// line. Directed y_dv injection covers the overflow and unexpected-result
// cases. A reference model with an expected-data queue is checked every cycle.
module tb_quadra_out_buf;
  localparam int Y_W = 24, LAT = 3, DEPTH = 8, LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst_b = 1'b0;
  logic x_dv = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
  logic [Y_W-1:0] x_val = '0;
  logic force_dv = 1'b0;
  logic [Y_W-1:0] force_y = '0;
  logic [LAT-1:0] pv;
  logic [Y_W-1:0] pd [LAT];
  logic y_dv;
  logic [Y_W-1:0] y;
  logic x_ready, out_valid, ovf, err_unexp;
  logic [Y_W-1:0] out_data;
  logic [LW-1:0] level;

  int n_run = 0, n_fail = 0, seq = 0;

  always #5 clk = ~clk;

  quadra_out_buf #(.Y_W(Y_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .x_dv(x_dv), .y(y), .y_dv(y_dv),
    .x_ready(x_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .ovf(ovf),
    .err_unexp(err_unexp), .clr_err(clr_err)
  );

  // Evaluator stand-in: fixed LAT-cycle delay line, flushed by reset.
  assign y_dv = pv[LAT-1] | force_dv;
  assign y    = force_dv ? force_y : pd[LAT-1];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], x_dv};
      pd[0] <= x_val;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  // Reference model.
  logic [Y_W-1:0] exp_q [$];
  int   m_lvl, m_if;
  logic m_run, m_ovf, m_unx;
  logic m_pop, m_full, m_push;
  assign m_pop  = (m_lvl != 0) && out_ready;
  assign m_full = (m_lvl == DEPTH);
  assign m_push = y_dv && (!m_full || m_pop);

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_run <= 1'b0; m_lvl <= 0; m_if <= 0; m_ovf <= 1'b0; m_unx <= 1'b0;
      exp_q.delete();
    end else begin
      m_run <= 1'b1;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(y);
      m_lvl <= m_lvl + int'(m_push) - int'(m_pop);
      m_ovf <= (m_ovf && !clr_err) || (y_dv && m_full && !m_pop);
      m_unx <= (m_unx && !clr_err) || (y_dv && !x_dv && m_if == 0);
      if (x_dv && !y_dv)                 m_if <= m_if + 1;
      else if (!x_dv && y_dv && m_if > 0) m_if <= m_if - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state();
    logic [Y_W-1:0] ed;
    ed = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("out_data",  32'(out_data),  32'(ed));
    chk("level",     32'(level),     32'(m_lvl));
    chk("x_ready",   32'(x_ready),   32'(m_run && (m_lvl + m_if < DEPTH)));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    chk("err_unexp", 32'(err_unexp), 32'(m_unx));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk_state();
  endtask

  // Issue on credit with out_ready low until credit stops, then let the pipe drain.
  task automatic fill_burst(output int issued);
    out_ready = 1'b0;
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      x_dv = x_ready;
      if (x_ready) begin
        x_val = 24'h100000 + Y_W'(seq);
        seq++;
        issued++;
      end
      step();
    end
    x_dv = 1'b0;
    for (int i = 0; i < LAT + 1; i++) step();
  endtask

  int issued;
  logic [Y_W-1:0] last;
  logic seen_abc;
  int pops;

  initial begin
    // Reset state.
    @(negedge clk);
    chk_state();
    chk("rst_xready", 32'(x_ready), 32'd0);
    rst_b = 1'b1;
    step();
    chk("run_xready", 32'(x_ready), 32'd1);

    // Single sample.
    x_dv = 1'b1; x_val = 24'h000123; out_ready = 1'b1;
    step();
    x_dv = 1'b0;
    step(); step(); step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'h000123);
    step();
    chk("t1_level", 32'(level), 32'd0);

    // Backpressure burst, then drain.
    fill_burst(issued);
    chk("burst_issues", 32'(issued), 32'd8);
    chk("burst_level",  32'(level),  32'd8);
    chk("burst_ovf",    32'(ovf),    32'd0);
    out_ready = 1'b1;
    step();
    chk("credit_back", 32'(x_ready), 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("drain_level", 32'(level), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    fill_burst(issued);
    force_dv = 1'b1; force_y = 24'h5A5A5A; out_ready = 1'b1;
    step();
    force_dv = 1'b0;
    chk("fpp_level", 32'(level), 32'd8);
    chk("fpp_ovf",   32'(ovf),   32'd0);
    pops = 0; last = '0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      last = out_data; pops++;
      step();
    end
    chk("fpp_pops", 32'(pops), 32'd8);
    chk("fpp_last", 32'(last), 32'h5A5A5A);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // Forced overflow.
    fill_burst(issued);
    force_dv = 1'b1; force_y = 24'hABCDEF;
    step();
    force_dv = 1'b0;
    chk("ovf_set",   32'(ovf),   32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    out_ready = 1'b1; seen_abc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid && out_data == 24'hABCDEF) seen_abc = 1'b1;
      step();
    end
    chk("ovf_dropped", 32'(seen_abc), 32'd0);

    // Unexpected result with nothing in flight.
    out_ready = 1'b0; force_dv = 1'b1; force_y = 24'h000777;
    step();
    force_dv = 1'b0;
    chk("unx_flag",  32'(err_unexp), 32'd1);
    chk("unx_level", 32'(level),     32'd1);
    step();
    out_ready = 1'b1; clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("unx_clr", 32'(err_unexp), 32'd0);
    // In-flight must still be zero: a fresh burst earns exactly DEPTH credits.
    fill_burst(issued);
    chk("post_unx_issues", 32'(issued), 32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();

    // Reset in the middle of a burst.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      x_dv = 1'b1; x_val = 24'h200000 + Y_W'(i);
      step();
    end
    x_dv = 1'b0;
    step();
    chk("mid_level", 32'(level), 32'd5);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_valid",  32'(out_valid), 32'd0);
    chk("arst_level",  32'(level),     32'd0);
    chk("arst_data",   32'(out_data),  32'd0);
    chk("arst_xready", 32'(x_ready),   32'd0);
    chk("arst_ovf",    32'(ovf),       32'd0);
    chk("arst_unx",    32'(err_unexp), 32'd0);
    step();
    rst_b = 1'b1;
    #1 chk("rel_xready0", 32'(x_ready), 32'd0);
    step();
    chk("rel_xready1", 32'(x_ready), 32'd1);
    for (int i = 0; i < LAT + 2; i++) step();
    chk("rel_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
